// File: rtl/moore_sym_arbiter_if.sv
// moore_sym_arbiter_if: requester / detector bus of the shared Moore-detector arbiter.
// slave  = arbiter side, master = requesters plus detector side.
interface moore_sym_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [2*NREQ-1:0] req_sym;
  logic [NREQ-1:0]   req_ready;
  logic [1:0]        sym_out;
  logic              sym_en;
  logic              fsm_out;
  logic              resp_valid;
  logic [ID_W-1:0]   resp_id;
  logic              resp_bit;
  logic              busy;
  logic [CNT_W-1:0]  sym_count;

  modport slave (
    input  req_valid, req_sym, fsm_out,
    output req_ready, sym_out, sym_en, resp_valid, resp_id, resp_bit, busy, sym_count
  );

  modport master (
    output req_valid, req_sym, fsm_out,
    input  req_ready, sym_out, sym_en, resp_valid, resp_id, resp_bit, busy, sym_count
  );
endinterface

// File: rtl/moore_sym_arbiter.sv
// moore_sym_arbiter: grants one of NREQ requesters at a time, issues its 2-bit symbol
// to a shared Moore detector with a one-cycle enable, waits SETTLE_CYC cycles and
// returns the sampled detector output to the granted requester.
// Optional build macro ARB_FIXED_PRIO_EN: lowest index always wins and the
// round-robin pointer is not built. Default (macro undefined) is round-robin.
module moore_sym_arbiter #(
  parameter int NREQ       = 4,
  parameter int SETTLE_CYC = 1,
  parameter int CNT_W      = 16
) (
  input logic                clock,
  input logic                reset,
  moore_sym_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // Settle down-counter is loaded with the index of the last SETTLE cycle.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [1:0]       sym_q, sym_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_bit_q, resp_bit_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [1:0]       sym_arr [NREQ];

  // Split the packed symbol bus into one 2-bit symbol per requester.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sym
      assign sym_arr[gi] = bus.req_sym[2*gi+1 : 2*gi];
    end
  endgenerate

`ifdef ARB_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest requesting index is kept last.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[ID_W'(k)]) begin
        win_found = 1'b1;
        win_id    = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  // Round-robin: first requester at or above rr_ptr, wrapping past NREQ-1.
  always_comb begin
    logic [ID_W:0] cand_sum;
    cand_sum  = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NREQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NREQ);
      end
      if (!win_found && bus.req_valid[cand_sum[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_id    = cand_sum[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the requester after the one being issued, modulo NREQ.
  always_comb begin
    logic [ID_W:0] ptr_inc;
    ptr_inc  = {1'b0, grant_q} + (ID_W+1)'(1);
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_ISSUE) begin
      rr_ptr_d = (ptr_inc >= (ID_W+1)'(NREQ)) ? '0 : ptr_inc[ID_W-1:0];
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`endif

  // Transaction sequencing: arbitrate, issue one symbol, settle, respond.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    sym_d      = sym_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    resp_bit_d = resp_bit_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        // RESP doubles as an arbitration slot so back-to-back grants lose no cycle.
        if (win_found) begin
          state_d = ST_ISSUE;
          grant_d = win_id;
          sym_d   = sym_arr[win_id];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d    = cnt_q + CNT_W'(1);
        settle_d = SETTLE_LAST;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) begin
          resp_bit_d = bus.fsm_out;
          state_d    = ST_RESP;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; asynchronous active-low reset aborts any transaction.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      sym_q      <= 2'b00;
      settle_q   <= 4'd0;
      cnt_q      <= '0;
      resp_bit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      sym_q      <= sym_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      resp_bit_q <= resp_bit_d;
    end
  end

  // Moore outputs decoded from registered state only.
  assign bus.req_ready  = (state_q == ST_ISSUE) ? (NREQ'(1) << grant_q) : '0;
  assign bus.sym_en     = (state_q == ST_ISSUE);
  assign bus.sym_out    = sym_q;
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_id    = grant_q;
  assign bus.resp_bit   = resp_bit_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.sym_count  = cnt_q;
endmodule
